// File: rtl/tlb_fill_sel_pkg.sv
// tlb_fill_sel_pkg: constants and types shared by the TLBFILL victim
// selector and the TLB/CSR control that talks to it.
//   TLBNUM - number of TLB entries (power of two, 2..64)
//   IDXW   - entry index width, log2(TLBNUM)
//   PTRW   - round-robin pointer width (same as the index width)
//   state_e - selector FSM encoding (IDLE=0, PICK=1, RESP=2)
package tlb_fill_sel_pkg;
    localparam int TLBNUM = 16;
    localparam int IDXW   = $clog2(TLBNUM);
    localparam int PTRW   = IDXW;

    typedef logic [TLBNUM-1:0] ent_vec_t;
    typedef logic [IDXW-1:0]   ent_idx_t;
    typedef logic [PTRW-1:0]   ptr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PICK = 2'd1,
        ST_RESP = 2'd2
    } state_e;
endpackage

// File: rtl/tlb_fill_sel_if.sv
// tlb_fill_sel_if: request/response bundle between the TLB-instruction
// control (master) and the victim selector (slave).
//   req_valid/req_ready    - fill-victim request handshake
//   entry_valid            - live per-entry valid bits, sampled on accept
//   ptr_clr                - synchronous clear of the round-robin pointer
//   resp_valid/resp_ready  - victim result handshake
//   resp_idx/resp_we/resp_free - chosen index, one-hot write-enable,
//                            and whether the victim was a free entry
interface tlb_fill_sel_if;
    import tlb_fill_sel_pkg::*;

    logic     req_valid;
    logic     req_ready;
    ent_vec_t entry_valid;
    logic     ptr_clr;
    logic     resp_valid;
    logic     resp_ready;
    ent_idx_t resp_idx;
    ent_vec_t resp_we;
    logic     resp_free;

    modport master (
        output req_valid, entry_valid, ptr_clr, resp_ready,
        input  req_ready, resp_valid, resp_idx, resp_we, resp_free
    );

    modport slave (
        input  req_valid, entry_valid, ptr_clr, resp_ready,
        output req_ready, resp_valid, resp_idx, resp_we, resp_free
    );
endinterface

// File: rtl/tlb_fill_sel_first_zero_pick.sv
// first_zero_pick: combinational lowest-zero finder.
//   vec      - input bit vector (N bits)
//   idx      - index of the lowest zero bit (0 when there is none)
//   any_zero - 1 when at least one bit of vec is zero
module first_zero_pick #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any_zero
);
    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        idx      = '0;
        any_zero = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!vec[i]) begin
                idx      = W'(i);
                any_zero = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tlb_fill_sel.sv
// tlb_fill_sel: victim-entry selector for TLBFILL.
// Snapshots entry_valid on request, picks the lowest invalid entry, or the
// round-robin pointer entry when all are valid, and returns the index plus
// a one-hot write-enable over a valid/ready handshake.
//   clk    - clock
//   resetn - asynchronous active-low reset
//   bus    - tlb_fill_sel_if.slave request/response bundle
module tlb_fill_sel
    import tlb_fill_sel_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    tlb_fill_sel_if.slave bus
);
    state_e   state_q, state_d;
    ptr_t     ptr_q, ptr_d;
    ent_vec_t snap_q, snap_d;
    ent_idx_t idx_q, idx_d;
    logic     free_q, free_d;
    logic     resp_valid_q, resp_valid_d;
    logic     req_ready_q, req_ready_d;

    ent_idx_t fz_idx;
    logic     fz_any;

    first_zero_pick #(.N(TLBNUM), .W(IDXW)) u_fz (
        .vec      (snap_q),
        .idx      (fz_idx),
        .any_zero (fz_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        snap_d       = snap_q;
        idx_d        = idx_q;
        free_d       = free_q;
        resp_valid_d = resp_valid_q;
        req_ready_d  = req_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    snap_d      = bus.entry_valid;
                    state_d     = ST_PICK;
                    req_ready_d = 1'b0;
                end
            end
            ST_PICK: begin
                // Pointer is read here, so a clear before this cycle wins.
                idx_d        = fz_any ? fz_idx : ent_idx_t'(ptr_q);
                free_d       = fz_any;
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    // Only pointer-sourced victims consume a pointer slot.
                    if (!free_q) ptr_d = ptr_q + PTRW'(1);
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
        // Clear has priority over a same-cycle advance.
        if (bus.ptr_clr) ptr_d = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            snap_q       <= '0;
            idx_q        <= '0;
            free_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
            free_q       <= free_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    // One-hot decode straight from flops; all zero outside RESP.
    always_comb begin
        bus.resp_we = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            bus.resp_we[i] = resp_valid_q && (idx_q == IDXW'(i));
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_idx   = idx_q;
    assign bus.resp_free  = free_q;
endmodule

// File: tb/tb_tlb_fill_sel.sv
// tb_tlb_fill_sel: directed bench for tlb_fill_sel. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
module tb_tlb_fill_sel;
    logic clk;
    logic resetn;
    int   n_chk;
    int   n_fail;

    tlb_fill_sel_if bus ();

    tlb_fill_sel dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full request/response round trip with resp_ready held high.
    // Optionally pulses ptr_clr in the handshake cycle.
    task automatic do_req(input logic [15:0] ev, input logic [3:0] e_idx,
                          input logic e_free, input logic clr);
        logic [15:0] we_exp;
        we_exp = 16'h1 << e_idx;
        chk("idle_rdy", 32'(bus.req_ready), 32'd1);
        bus.req_valid   = 1'b1;
        bus.entry_valid = ev;
        bus.resp_ready  = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pick_vld", 32'(bus.resp_valid), 32'd0);
        chk("pick_rdy", 32'(bus.req_ready), 32'd0);
        chk("pick_we", 32'(bus.resp_we), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("resp_vld", 32'(bus.resp_valid), 32'd1);
        chk("resp_idx", 32'(bus.resp_idx), 32'(e_idx));
        chk("resp_free", 32'(bus.resp_free), 32'(e_free));
        chk("resp_we", 32'(bus.resp_we), 32'(we_exp));
        bus.ptr_clr = clr;
        @(posedge clk); @(negedge clk);
        bus.ptr_clr = 1'b0;
        chk("post_vld", 32'(bus.resp_valid), 32'd0);
        chk("post_rdy", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        n_chk           = 0;
        n_fail          = 0;
        resetn          = 1'b0;
        bus.req_valid   = 1'b0;
        bus.entry_valid = '0;
        bus.ptr_clr     = 1'b0;
        bus.resp_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(bus.req_ready), 32'd1);
        chk("rst_vld", 32'(bus.resp_valid), 32'd0);
        chk("rst_idx", 32'(bus.resp_idx), 32'd0);
        chk("rst_we", 32'(bus.resp_we), 32'd0);
        chk("rst_free", 32'(bus.resp_free), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: free entry 3; pointer untouched
        do_req(16'hFFF7, 4'd3, 1'b1, 1'b0);

        // 2+3: all valid walks the pointer 0..15, then wraps to 0
        for (int i = 0; i < 16; i++) do_req(16'hFFFF, 4'(i), 1'b0, 1'b0);
        do_req(16'hFFFF, 4'd0, 1'b0, 1'b0);   // ptr now 1

        // all-zero snapshot picks entry 0 as free
        do_req(16'h0000, 4'd0, 1'b1, 1'b0);

        // 4: stall in RESP, snapshot ignores later entry_valid changes
        bus.req_valid   = 1'b1;
        bus.entry_valid = 16'hFFFE;
        bus.resp_ready  = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.entry_valid = 16'hFFFF;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b1;              // second request must wait
        for (int c = 0; c < 5; c++) begin
            chk("stall_vld", 32'(bus.resp_valid), 32'd1);
            chk("stall_idx", 32'(bus.resp_idx), 32'd0);
            chk("stall_free", 32'(bus.resp_free), 32'd1);
            chk("stall_we", 32'(bus.resp_we), 32'h0001);
            chk("stall_rdy", 32'(bus.req_ready), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("stall_done_vld", 32'(bus.resp_valid), 32'd0);
        chk("stall_done_rdy", 32'(bus.req_ready), 32'd1);

        // 5: ptr 1..5 consumed, then clear at the handshake of idx 6
        for (int i = 1; i < 6; i++) do_req(16'hFFFF, 4'(i), 1'b0, 1'b0);
        do_req(16'hFFFF, 4'd6, 1'b0, 1'b1);
        do_req(16'hFFFF, 4'd0, 1'b0, 1'b0);   // ptr now 1

        // 6: reset asserted during PICK
        bus.req_valid   = 1'b1;
        bus.entry_valid = 16'hFFFF;
        bus.resp_ready  = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_rst_rdy", 32'(bus.req_ready), 32'd0);
        resetn = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_we", 32'(bus.resp_we), 32'd0);
        chk("mid_rst_rdy", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_vld", 32'(bus.resp_valid), 32'd0);
        end
        do_req(16'hFFFF, 4'd0, 1'b0, 1'b0);
        do_req(16'hFFFF, 4'd1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
